// File: rtl/loader_pkg.sv
// Shared types and default geometry for the boot-time program loader.
package loader_pkg;

    localparam int LOADER_ADDR_W = 4;
    localparam int LOADER_DATA_W = 8;
    localparam int LOADER_LEN    = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        VERIFY_RD,
        VERIFY_CHK,
        RUN,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/loader_checksum.sv
// Modulo-2^DATA_W byte accumulator with clear and add-enable.
// Only compiled when LOADER_VERIFY_EN is defined; the default build needs no checksum.
`ifdef LOADER_VERIFY_EN
module loader_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_val,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_d, sum_q;

    always_comb begin
        sum_d = sum_q;
        if (clr)
            sum_d = '0;
        else if (add_en)
            sum_d = sum_q + add_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule
`endif

// File: rtl/program_loader.sv
// Streams a program image into the shared RAM, then releases the CPU.
// Define LOADER_VERIFY_EN to add a checksum readback pass before RUN.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W   = LOADER_ADDR_W,
    parameter int DATA_W   = LOADER_DATA_W,
    parameter int LOAD_LEN = LOADER_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [DATA_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enable,
    output logic              ram_read_enable,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              active_cpu,
    output logic              load_done,
    output logic              load_error
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LOAD_LEN - 1);

    loader_state_t     state_d, state_q;
    logic [ADDR_W-1:0] cnt_d, cnt_q, addr_d, addr_q;
    logic [DATA_W-1:0] data_d, data_q;
    logic              we_d, we_q, br_d, br_q, done_d, done_q, act_d, act_q;

`ifdef LOADER_VERIFY_EN
    logic              re_d, re_q, err_d, err_q;
    logic              sum_clr, sum_add, rb_clr, rb_add;
    logic [DATA_W-1:0] load_sum, rb_sum, rb_next;

    loader_checksum #(.DATA_W(DATA_W)) u_load_sum (
        .clk(clk), .rst_n(rst_n), .clr(sum_clr), .add_en(sum_add),
        .add_val(byte_in), .sum(load_sum)
    );

    loader_checksum #(.DATA_W(DATA_W)) u_rb_sum (
        .clk(clk), .rst_n(rst_n), .clr(rb_clr), .add_en(rb_add),
        .add_val(ram_data_out), .sum(rb_sum)
    );

    // The final readback byte has not been accumulated yet when compared.
    assign rb_next = rb_sum + ram_data_out;
`else
    logic unused_ram_data;
    assign unused_ram_data = ^ram_data_out;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        br_d    = 1'b0;
        done_d  = 1'b0;
        act_d   = act_q;
`ifdef LOADER_VERIFY_EN
        re_d    = 1'b0;
        err_d   = err_q;
        sum_clr = 1'b0;
        sum_add = 1'b0;
        rb_clr  = 1'b0;
        rb_add  = 1'b0;
`endif
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (load_start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    br_d    = 1'b1;
                    act_d   = 1'b0;
`ifdef LOADER_VERIFY_EN
                    err_d   = 1'b0;
                    sum_clr = 1'b1;
`endif
                end
            end
            LOAD: begin
                if (byte_valid && br_q) begin
                    state_d = WRITE;
                    addr_d  = cnt_q;
                    data_d  = byte_in;
                    we_d    = 1'b1;
`ifdef LOADER_VERIFY_EN
                    sum_add = 1'b1;
`endif
                end else begin
                    br_d = 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q != LAST) begin
                    state_d = LOAD;
                    cnt_d   = cnt_q + ADDR_W'(1);
                    br_d    = 1'b1;
                end else begin
`ifdef LOADER_VERIFY_EN
                    state_d = VERIFY_RD;
                    cnt_d   = '0;
                    rb_clr  = 1'b1;
`else
                    state_d = RUN;
                    act_d   = 1'b1;
                    done_d  = 1'b1;
                    addr_d  = '0;
                    data_d  = '0;
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            VERIFY_RD: begin
                state_d = VERIFY_CHK;
                addr_d  = cnt_q;
                data_d  = '0;
                re_d    = 1'b1;
            end
            VERIFY_CHK: begin
                rb_add = 1'b1;
                if (cnt_q == LAST) begin
                    addr_d = '0;
                    if (rb_next == load_sum) begin
                        state_d = RUN;
                        act_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERROR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = VERIFY_RD;
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            br_q    <= 1'b0;
            done_q  <= 1'b0;
            act_q   <= 1'b0;
`ifdef LOADER_VERIFY_EN
            re_q    <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            br_q    <= br_d;
            done_q  <= done_d;
            act_q   <= act_d;
`ifdef LOADER_VERIFY_EN
            re_q    <= re_d;
            err_q   <= err_d;
`endif
        end
    end

    assign byte_ready       = br_q;
    assign ram_address      = addr_q;
    assign ram_data_in      = data_q;
    assign ram_write_enable = we_q;
    assign active_cpu       = act_q;
    assign load_done        = done_q;
`ifdef LOADER_VERIFY_EN
    assign ram_read_enable  = re_q;
    assign load_error       = err_q;
`else
    assign ram_read_enable  = 1'b0;
    assign load_error       = 1'b0;
`endif

endmodule
